// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle MIPS-subset control unit.
//
// Sequences FETCH -> DECODE -> execute/memory/writeback states for addu,
// subu, ori, lui, lw, sw, beq and j. Every memory access (FETCH, MEM_RD,
// MEM_WR) waits for mem_ready. If the wait lasts WAIT_MAX cycles, err is set
// and the FSM parks in HALT until rst.
//
// Build option: define MC_CTRL_ILLEGAL_TRAP_EN so that an illegal instruction
// in DECODE sets err and halts. Without it, an illegal instruction is treated
// as a NOP and DECODE returns to FETCH.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   Op, Funct       instruction[31:26] / instruction[5:0]
//   Zero            ALU equality flag (used in BRANCH)
//   mem_ready       memory completes the current access this cycle
//   PCWrite, IRWrite, RegWrite, MemRead, MemWrite   strobes
//   IorD, RegDst, MemtoReg, ALUSrcA                 datapath selects
//   PCSrc[1:0], ALUSrcB[1:0], ALUOp[4:0]            multi-bit selects
//   err             sticky fault flag
//   state[3:0]      current FSM state (debug)
module mc_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUSrcB,
  output logic [4:0] ALUOp,
  output logic       err,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_R   = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd11;

  localparam logic [4:0] ALU_ADDU = 5'd0;
  localparam logic [4:0] ALU_SUBU = 5'd1;
  localparam logic [4:0] ALU_OR   = 5'd2;
  localparam logic [4:0] ALU_EQL  = 5'd3;
  localparam logic [4:0] ALU_LUI  = 5'd4;

  // wait_last is the count seen during the final allowed wait cycle;
  // a miss in that cycle is the WAIT_MAX-th and triggers the timeout.
  localparam logic [7:0] WAIT_TOP  = 8'(WAIT_MAX);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  logic [3:0] next_state;
  logic [7:0] wait_cnt;
  logic       set_err;
  logic       in_mem;
  logic       timeout;

  logic is_rtype, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;

  assign is_rtype = (Op == 6'b000000);
  assign is_addu  = is_rtype && (Funct == 6'b100001);
  assign is_subu  = is_rtype && (Funct == 6'b100011);
  assign is_ori   = (Op == 6'b001101);
  assign is_lui   = (Op == 6'b001111);
  assign is_lw    = (Op == 6'b100011);
  assign is_sw    = (Op == 6'b101011);
  assign is_beq   = (Op == 6'b000100);
  assign is_j     = (Op == 6'b000010);

  assign in_mem  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout = in_mem && !mem_ready && (wait_cnt == WAIT_LAST);

  // Next-state selection; a timeout only fires when mem_ready is low,
  // so a same-cycle completion always wins.
  always_comb begin
    next_state = state;
    set_err    = 1'b0;
    case (state)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          if (state == S_FETCH)       next_state = S_DECODE;
          else if (state == S_MEM_RD) next_state = S_WB_MEM;
          else                        next_state = S_FETCH;
        end else if (timeout) begin
          next_state = S_HALT;
          set_err    = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_addu || is_subu)    next_state = S_EXEC_R;
        else if (is_ori || is_lui) next_state = S_EXEC_I;
        else if (is_lw || is_sw)   next_state = S_ADDR;
        else if (is_beq)           next_state = S_BRANCH;
        else if (is_j)             next_state = S_JUMP;
        else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          next_state = S_HALT;
          set_err    = 1'b1;
`else
          next_state = S_FETCH;
`endif
        end
      end
      S_EXEC_R, S_EXEC_I: next_state = S_WB_R;
      S_ADDR:             next_state = is_lw ? S_MEM_RD : S_MEM_WR;
      S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_HALT:             next_state = S_HALT;
      default:            next_state = S_FETCH;
    endcase
  end

  // State, sticky error and wait counter. The counter restarts on every
  // state change, so it is zero on entry to each memory state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      if (set_err) err <= 1'b1;
      if (next_state != state)
        wait_cnt <= 8'd0;
      else if (in_mem && !mem_ready && (wait_cnt != WAIT_TOP))
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Output decode from the current state (plus mem_ready in FETCH and
  // Zero in BRANCH). Write strobes are suppressed while rst is held so an
  // aborted access cannot commit anything.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcB  = 2'b00;
    ALUOp    = ALU_ADDU;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = is_subu ? ALU_SUBU : ALU_ADDU;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        if (is_lui) begin
          ALUSrcB = 2'b10;
          ALUOp   = ALU_LUI;
        end else begin
          ALUSrcB = 2'b11;
          ALUOp   = ALU_OR;
        end
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = is_rtype;
      end
      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_EQL;
        PCSrc   = 2'b01;
        PCWrite = Zero;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl -- directed testbench for mc_ctrl with WAIT_MAX=4.
//
// Inputs change just after each falling edge; outputs are checked 1 ns
// later, well away from the rising (active) edge.
module tb_mc_ctrl;

  localparam logic [4:0] A_ADDU = 5'd0;
  localparam logic [4:0] A_SUBU = 5'd1;
  localparam logic [4:0] A_OR   = 5'd2;
  localparam logic [4:0] A_EQL  = 5'd3;
  localparam logic [4:0] A_LUI  = 5'd4;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, memReady;
  logic       pcWrite, irWrite, regWrite, memRead, memWrite;
  logic       iorD, regDst, memtoReg, aluSrcA;
  logic [1:0] pcSrc, aluSrcB;
  logic [4:0] aluOp;
  logic       err;
  logic [3:0] state;

  int testsRun    = 0;
  int testsFailed = 0;

  mc_ctrl #(.WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .Op(op), .Funct(funct), .Zero(zero),
    .mem_ready(memReady), .PCWrite(pcWrite), .IRWrite(irWrite),
    .RegWrite(regWrite), .MemRead(memRead), .MemWrite(memWrite),
    .IorD(iorD), .RegDst(regDst), .MemtoReg(memtoReg), .ALUSrcA(aluSrcA),
    .PCSrc(pcSrc), .ALUSrcB(aluSrcB), .ALUOp(aluOp), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input logic z, input logic r);
    op = o; funct = f; zero = z; memReady = r;
    #1;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    nextCycle();
    rst = 1'b0;
  endtask

  // Runs FETCH (mem_ready=1) and DECODE for one instruction, leaving the
  // bench at the start of the cycle after DECODE.
  task automatic fetchDecode(input logic [5:0] o, input logic [5:0] f);
    applyStimulus(o, f, 1'b0, 1'b1);
    checkOutput("fetch_state", 32'(state), 32'd0);
    nextCycle();
    applyStimulus(o, f, 1'b0, 1'b1);
    checkOutput("decode_state", 32'(state), 32'd1);
    nextCycle();
  endtask

  initial begin
    rst = 1'b1; op = '0; funct = '0; zero = 1'b0; memReady = 1'b1;
    #2;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_memread", 32'(memRead), 32'd1);
    checkOutput("rst_pcwrite_gated", 32'(pcWrite), 32'd0);
    nextCycle();
    rst = 1'b0;

    // addu
    applyStimulus(OP_R, F_ADDU, 1'b0, 1'b1);
    checkOutput("addu_f_irwrite", 32'(irWrite), 32'd1);
    checkOutput("addu_f_pcwrite", 32'(pcWrite), 32'd1);
    checkOutput("addu_f_alusrcb", 32'(aluSrcB), 32'd1);
    checkOutput("addu_f_iord", 32'(iorD), 32'd0);
    nextCycle();
    applyStimulus(OP_R, F_ADDU, 1'b0, 1'b1);
    checkOutput("addu_decode", 32'(state), 32'd1);
    nextCycle();
    applyStimulus(OP_R, F_ADDU, 1'b0, 1'b1);
    checkOutput("addu_exec_state", 32'(state), 32'd2);
    checkOutput("addu_exec_aluop", 32'(aluOp), 32'(A_ADDU));
    checkOutput("addu_exec_srca", 32'(aluSrcA), 32'd1);
    checkOutput("addu_exec_srcb", 32'(aluSrcB), 32'd0);
    nextCycle();
    applyStimulus(OP_R, F_ADDU, 1'b0, 1'b1);
    checkOutput("addu_wb_state", 32'(state), 32'd7);
    checkOutput("addu_wb_regwrite", 32'(regWrite), 32'd1);
    checkOutput("addu_wb_regdst", 32'(regDst), 32'd1);
    checkOutput("addu_wb_memtoreg", 32'(memtoReg), 32'd0);
    nextCycle();
    applyStimulus(OP_R, F_ADDU, 1'b0, 1'b1);
    checkOutput("addu_back_fetch", 32'(state), 32'd0);

    // subu
    fetchDecode(OP_R, F_SUBU);
    applyStimulus(OP_R, F_SUBU, 1'b0, 1'b1);
    checkOutput("subu_exec_aluop", 32'(aluOp), 32'(A_SUBU));
    nextCycle();
    nextCycle();

    // ori
    fetchDecode(OP_ORI, 6'd0);
    applyStimulus(OP_ORI, 6'd0, 1'b0, 1'b1);
    checkOutput("ori_state", 32'(state), 32'd3);
    checkOutput("ori_srcb", 32'(aluSrcB), 32'd3);
    checkOutput("ori_aluop", 32'(aluOp), 32'(A_OR));
    nextCycle();
    applyStimulus(OP_ORI, 6'd0, 1'b0, 1'b1);
    checkOutput("ori_wb_regdst", 32'(regDst), 32'd0);
    checkOutput("ori_wb_regwrite", 32'(regWrite), 32'd1);
    nextCycle();

    // lui
    fetchDecode(OP_LUI, 6'd0);
    applyStimulus(OP_LUI, 6'd0, 1'b0, 1'b1);
    checkOutput("lui_srcb", 32'(aluSrcB), 32'd2);
    checkOutput("lui_aluop", 32'(aluOp), 32'(A_LUI));
    nextCycle();
    nextCycle();

    // lw with three not-ready cycles in MEM_RD (boundary: 3 of WAIT_MAX=4)
    fetchDecode(OP_LW, 6'd0);
    applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
    checkOutput("lw_addr_state", 32'(state), 32'd4);
    checkOutput("lw_addr_srcb", 32'(aluSrcB), 32'd2);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
      checkOutput("lw_wait_state", 32'(state), 32'd5);
      checkOutput("lw_wait_memread", 32'(memRead), 32'd1);
      checkOutput("lw_wait_iord", 32'(iorD), 32'd1);
      nextCycle();
    end
    applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    checkOutput("lw_last_memread", 32'(memRead), 32'd1);
    checkOutput("lw_last_state", 32'(state), 32'd5);
    nextCycle();
    applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    checkOutput("lw_wbmem_state", 32'(state), 32'd8);
    checkOutput("lw_wbmem_memtoreg", 32'(memtoReg), 32'd1);
    checkOutput("lw_wbmem_regwrite", 32'(regWrite), 32'd1);
    checkOutput("lw_wbmem_regdst", 32'(regDst), 32'd0);
    checkOutput("lw_err", 32'(err), 32'd0);
    nextCycle();

    // beq taken / not taken
    fetchDecode(OP_BEQ, 6'd0);
    applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b1);
    checkOutput("beq1_state", 32'(state), 32'd9);
    checkOutput("beq1_pcwrite", 32'(pcWrite), 32'd1);
    checkOutput("beq1_pcsrc", 32'(pcSrc), 32'd1);
    checkOutput("beq1_aluop", 32'(aluOp), 32'(A_EQL));
    nextCycle();
    fetchDecode(OP_BEQ, 6'd0);
    applyStimulus(OP_BEQ, 6'd0, 1'b0, 1'b1);
    checkOutput("beq0_pcwrite", 32'(pcWrite), 32'd0);
    checkOutput("beq0_pcsrc", 32'(pcSrc), 32'd1);
    nextCycle();

    // j
    fetchDecode(OP_J, 6'd0);
    applyStimulus(OP_J, 6'd0, 1'b0, 1'b1);
    checkOutput("j_state", 32'(state), 32'd10);
    checkOutput("j_pcwrite", 32'(pcWrite), 32'd1);
    checkOutput("j_pcsrc", 32'(pcSrc), 32'd2);
    nextCycle();

    // sw aborted by reset in MEM_WR
    fetchDecode(OP_SW, 6'd0);
    applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0);
    checkOutput("sw_memwr_state", 32'(state), 32'd6);
    checkOutput("sw_memwrite", 32'(memWrite), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("sw_rst_state", 32'(state), 32'd0);
    checkOutput("sw_rst_memwrite", 32'(memWrite), 32'd0);
    checkOutput("sw_rst_err", 32'(err), 32'd0);
    nextCycle();
    rst = 1'b0;

    // illegal opcode
    fetchDecode(OP_BAD, 6'd0);
    applyStimulus(OP_BAD, 6'd0, 1'b0, 1'b1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    checkOutput("illegal_state", 32'(state), 32'd11);
    checkOutput("illegal_err", 32'(err), 32'd1);
    doReset();
`else
    checkOutput("illegal_state", 32'(state), 32'd0);
    checkOutput("illegal_err", 32'(err), 32'd0);
`endif

    // FETCH timeout: still waiting after 3 misses, HALT after the 4th
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_R, F_ADDU, 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(OP_R, F_ADDU, 1'b0, 1'b0);
    checkOutput("to_pre_state", 32'(state), 32'd0);
    checkOutput("to_pre_err", 32'(err), 32'd0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_R, F_ADDU, 1'b1, 1'b1);
      checkOutput("halt_state", 32'(state), 32'd11);
      checkOutput("halt_err", 32'(err), 32'd1);
      checkOutput("halt_memread", 32'(memRead), 32'd0);
      checkOutput("halt_pcwrite", 32'(pcWrite), 32'd0);
      checkOutput("halt_irwrite", 32'(irWrite), 32'd0);
      nextCycle();
    end
    doReset();
    applyStimulus(OP_R, F_ADDU, 1'b0, 1'b1);
    checkOutput("post_rst_state", 32'(state), 32'd0);
    checkOutput("post_rst_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
